// File: rtl/pipe_pkg.sv
// Shared defaults and helpers for the pipe register chain.
package pipe_pkg;

  localparam int unsigned PIPE_N_DEF     = 16;
  localparam int unsigned PIPE_DEPTH_DEF = 4;

  // Bits needed to hold an occupancy count of 0..depth inclusive.
  function automatic int unsigned count_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// One register stage of the chain: N-bit payload plus valid flag.
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int unsigned N = PIPE_N_DEF
) (
  input  logic         clk_i,
  input  logic         clear_i,
  input  logic         load_i,
  input  logic         flush_i,
  input  logic [N-1:0] data_i,
  input  logic         valid_i,
  output logic [N-1:0] data_o,
  output logic         valid_o
);

  logic [N-1:0] data_q, data_d;
  logic         valid_q, valid_d;

  // Payload only moves with a valid token so empty stages keep their last value.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = valid_i;
      if (valid_i) begin
        data_d = data_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/pipe_reg_chain.sv
// Elastic register chain with bubble-collapsing ready propagation,
// chain enable, flush and occupancy count.
module pipe_reg_chain
  import pipe_pkg::*;
#(
  parameter int unsigned N     = PIPE_N_DEF,
  parameter int unsigned DEPTH = PIPE_DEPTH_DEF
) (
  input  logic                        C,
  input  logic                        CLR,
  input  logic                        CE,
  input  logic                        FLUSH,
  input  logic [N-1:0]                D,
  input  logic                        D_VALID,
  output logic                        D_READY,
  output logic [N-1:0]                O,
  output logic                        O_VALID,
  input  logic                        O_READY,
  output logic [count_w(DEPTH)-1:0]   COUNT
);

  localparam int unsigned CW = count_w(DEPTH);

  logic [N-1:0] data [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [DEPTH:0]   rdy;

  // A stage may load when it is empty or its occupant moves on, so empty
  // stages upstream of a stalled tail keep filling.
  always_comb begin
    rdy        = '0;
    rdy[DEPTH] = O_READY;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      rdy[i] = !valid[i] | rdy[i+1];
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    logic [N-1:0] din;
    logic         vin;

    if (g == 0) begin : g_head
      assign din = D;
      assign vin = D_VALID;
    end else begin : g_body
      assign din = data[g-1];
      assign vin = valid[g-1];
    end

    pipe_stage #(
      .N(N)
    ) u_stage (
      .clk_i  (C),
      .clear_i(CLR),
      .load_i (CE & rdy[g]),
      .flush_i(FLUSH),
      .data_i (din),
      .valid_i(vin),
      .data_o (data[g]),
      .valid_o(valid[g])
    );
  end

  always_comb begin
    COUNT = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      COUNT = COUNT + CW'(valid[i]);
    end
  end

  assign D_READY = CE & !FLUSH & rdy[0];
  assign O_VALID = CE & valid[DEPTH-1];
  assign O       = data[DEPTH-1];

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Randomised and directed bench for pipe_reg_chain against a queue model.
module tb_pipe_reg_chain;

  localparam int unsigned N     = 16;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic          C = 1'b0;
  logic          CLR, CE, FLUSH, D_VALID, D_READY, O_VALID, O_READY;
  logic [N-1:0]  D, O;
  logic [CW-1:0] COUNT;

  always #5 C = ~C;

  pipe_reg_chain #(
    .N    (N),
    .DEPTH(DEPTH)
  ) dut (
    .C      (C),
    .CLR    (CLR),
    .CE     (CE),
    .FLUSH  (FLUSH),
    .D      (D),
    .D_VALID(D_VALID),
    .D_READY(D_READY),
    .O      (O),
    .O_VALID(O_VALID),
    .O_READY(O_READY),
    .COUNT  (COUNT)
  );

  // Model: ordered list of in-flight entries with their stage position.
  typedef struct {
    logic [N-1:0] d;
    int           pos;
  } ent_t;

  ent_t         q[$];
  logic [N-1:0] last_out;
  bit           mdl_ok;
  bit           acc;
  int           n_vec, n_err;
  int           nxt, exp_out;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic clr, input logic ce, input logic flush, input logic dv,
                       input logic [N-1:0] d, input logic ordy);
    int np[$];
    bit rm;
    bit occ0;
    bit exp_rdy;
    int lim;
    @(negedge C);
    CLR = clr; CE = ce; FLUSH = flush; D_VALID = dv; D = d; O_READY = ordy;
    #1;
    rm = 1'b0;
    np = {};
    // Oldest first: each entry advances one slot unless blocked by the one ahead.
    for (int k = 0; k < q.size(); k++) begin
      if (k == 0) begin
        if (q[0].pos == DEPTH - 1) begin
          rm = ordy;
          np.push_back(DEPTH - 1);
        end else begin
          np.push_back(q[0].pos + 1);
        end
      end else begin
        lim = (k == 1 && rm) ? DEPTH - 1 : np[k-1] - 1;
        np.push_back((q[k].pos + 1 < lim) ? q[k].pos + 1 : lim);
      end
    end
    occ0    = q.size() > 0 && !(q.size() == 1 && rm) && np[q.size()-1] == 0;
    exp_rdy = ce && !flush && !occ0;
    if (mdl_ok) begin
      chk("d_ready", D_READY, exp_rdy);
      chk("o_valid", O_VALID, ce && q.size() > 0 && q[0].pos == DEPTH - 1);
      chk("o", O, last_out);
      chk("count", COUNT, q.size());
    end
    acc = dv && exp_rdy && !clr;
    if (clr) begin
      q.delete();
      last_out = '0;
      mdl_ok   = 1'b1;
    end else if (flush) begin
      q.delete();
    end else if (ce) begin
      for (int k = 0; k < q.size(); k++) begin
        if (q[k].pos != DEPTH - 1 && np[k] == DEPTH - 1) last_out = q[k].d;
        q[k].pos = np[k];
      end
      if (rm) void'(q.pop_front());
      if (dv && exp_rdy) q.push_back('{d: d, pos: 0});
    end
  endtask

  initial begin
    CLR = 1'b1; CE = 1'b0; FLUSH = 1'b0; D_VALID = 1'b0; D = '0; O_READY = 1'b0;
    n_vec = 0; n_err = 0; mdl_ok = 1'b0; last_out = '0; acc = 1'b0;

    drive(1, 1, 0, 0, '0, 0);
    drive(1, 0, 0, 0, '0, 0);
    drive(0, 1, 0, 0, '0, 0);
    chk("rst_o", O, 0);
    chk("rst_ovalid", O_VALID, 0);
    chk("rst_count", COUNT, 0);
    chk("rst_dready", D_READY, 1);

    // Fill with 0xAAAA, then clear while full.
    repeat (4) drive(0, 1, 0, 1, 16'hAAAA, 0);
    drive(0, 1, 0, 0, '0, 0);
    chk("full_count", COUNT, 4);
    chk("full_o", O, 16'hAAAA);
    chk("full_dready", D_READY, 0);
    drive(1, 1, 0, 1, 16'h5555, 1);
    drive(0, 1, 0, 0, '0, 1);
    chk("clr_o", O, 16'h0000);
    chk("clr_ovalid", O_VALID, 0);
    chk("clr_count", COUNT, 0);
    chk("clr_dready", D_READY, 1);

    // Streaming 1..8 with downstream always ready.
    nxt = 1; exp_out = 1;
    for (int c = 0; c < 16; c++) begin
      drive(0, 1, 0, nxt <= 8, N'(nxt), 1);
      if (O_VALID) begin
        chk("stream_cycle", c, 4 + exp_out - 1);
        chk("stream_o", O, exp_out);
        exp_out++;
      end
      if (acc) nxt++;
    end
    chk("stream_total", exp_out, 9);

    // Full with simultaneous in/out transfer.
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 0, 1, N'(16'h11 + i), 0);
      if (i == 4) begin
        chk("bp_dready", D_READY, 0);
        chk("bp_count", COUNT, 4);
      end
    end
    drive(0, 1, 0, 1, 16'h0015, 1);
    chk("xfer_o", O, 16'h0011);
    chk("xfer_ovalid", O_VALID, 1);
    chk("xfer_dready", D_READY, 1);
    drive(0, 1, 0, 0, '0, 0);
    chk("xfer_count", COUNT, 4);
    chk("xfer_o2", O, 16'h0012);
    repeat (6) drive(0, 1, 0, 0, '0, 1);

    // Bubble collapse behind a stalled tail.
    drive(0, 1, 0, 1, 16'h00F0, 0);
    repeat (3) drive(0, 1, 0, 0, '0, 0);
    drive(0, 1, 0, 1, 16'h00F1, 0);
    chk("col_tail", O, 16'h00F0);
    repeat (3) drive(0, 1, 0, 0, '0, 0);
    drive(0, 1, 0, 0, '0, 1);
    chk("col_count", COUNT, 2);
    chk("col_o", O, 16'h00F0);
    drive(0, 1, 0, 0, '0, 1);
    chk("col_o2", O, 16'h00F1);
    chk("col_ovalid2", O_VALID, 1);
    drive(0, 1, 0, 0, '0, 1);
    chk("col_count0", COUNT, 0);

    // Flush with three held and a competing push.
    for (int i = 0; i < 3; i++) drive(0, 1, 0, 1, N'(16'h31 + i), 0);
    drive(0, 1, 1, 1, 16'h1234, 0);
    chk("fl_count_pre", COUNT, 3);
    chk("fl_dready", D_READY, 0);
    drive(0, 1, 0, 0, '0, 1);
    chk("fl_count", COUNT, 0);
    chk("fl_ovalid", O_VALID, 0);
    repeat (6) begin
      drive(0, 1, 0, 0, '0, 1);
      chk("fl_none", O_VALID, 0);
    end

    // Chain enable dropped mid-stream.
    nxt = 16'h41; exp_out = 16'h41;
    for (int c = 0; c < 20; c++) begin
      drive(0, !(c >= 3 && c < 6), 0, nxt <= 16'h48, N'(nxt), 1);
      if (c >= 3 && c < 6) begin
        chk("ce_dready", D_READY, 0);
        chk("ce_ovalid", O_VALID, 0);
        chk("ce_count", COUNT, 3);
      end
      if (O_VALID) begin
        chk("ce_seq", O, exp_out);
        exp_out++;
      end
      if (acc) nxt++;
    end
    chk("ce_total", exp_out, 16'h49);

    // Randomised traffic.
    for (int c = 0; c < 3000; c++) begin
      drive($urandom_range(63) == 0, $urandom_range(7) != 0, $urandom_range(15) == 0,
            $urandom_range(3) != 0, N'($urandom), $urandom_range(1) == 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_reg_chain.md
PIPE_REG_CHAIN -- requirements
Module: pipe_reg_chain

Interface
REQ-001 Parameter N, default 16, data width in bits (N >= 1).
REQ-002 Parameter DEPTH, default 4, number of register stages (DEPTH >= 1).
REQ-003 C  input  1  clock; all state updates on rising edge of C only.
REQ-004 CLR  input  1  reset, synchronous, active-high.
REQ-005 CE  input  1  chain enable; 0 freezes all state.
REQ-006 FLUSH  input  1  synchronous discard of all held entries.
REQ-007 D  input  N  input data.
REQ-008 D_VALID  input  1  input data valid.
REQ-009 D_READY  output  1  chain can accept D this cycle.
REQ-010 O  output  N  data of last stage (stage DEPTH-1).
REQ-011 O_VALID  output  1  valid flag of last stage.
REQ-012 O_READY  input  1  downstream accepts O this cycle.
REQ-013 COUNT  output  $clog2(DEPTH+1)  number of stages currently holding valid data.

Function
REQ-014 Each stage i holds data[i] (N bits) and valid[i]; stage 0 is the input side, stage DEPTH-1 drives O/O_VALID.
REQ-015 Stage ready: rdy[DEPTH] = O_READY; rdy[i] = !valid[i] | rdy[i+1] (bubble collapsing; a stalled tail does not block empty upstream stages).
REQ-016 D_READY = CE & !FLUSH & rdy[0], combinational.
REQ-017 O_VALID = CE & valid[DEPTH-1]; O = data[DEPTH-1] at all times.
REQ-018 Input transfer when D_VALID & D_READY; output transfer when O_VALID & O_READY.
REQ-019 With CE=1, FLUSH=0, CLR=0, each edge for every stage with rdy[i]=1: valid[i] <= valid[i-1] (stage 0: D_VALID); data[i] <= data[i-1] (stage 0: D) only when the incoming valid is 1, else data[i] holds.
REQ-020 Stages with rdy[i]=0 hold data and valid unchanged.
REQ-021 Latency: data accepted on edge k appears on O with O_VALID=1 after edge k+DEPTH-1 when no stall occurs (i.e. DEPTH edges from D sampled to O registered at last stage, counting the accepting edge).
REQ-022 Throughput: one transfer per cycle sustained when O_READY=1 and D_VALID=1.
REQ-023 Ordering preserved; no entry duplicated or dropped except by FLUSH or CLR.
REQ-024 Full (all valid, O_READY=0): D_READY=0, all state held.
REQ-025 Simultaneous input and output transfer when full: both occur, COUNT unchanged.
REQ-026 CE=0: no state change, D_READY=0, O_VALID=0; state resumes unchanged when CE returns to 1.
REQ-027 FLUSH=1 (CE ignored): all valid[i] <= 0 on the edge; data[i] unchanged; no input accepted that cycle; COUNT=0 the next cycle.
REQ-028 COUNT = popcount(valid[]), registered-state derived, bounded 0..DEPTH.
REQ-029 Priority: CLR > FLUSH > CE.

Reset
REQ-030 CLR=1 at an edge: all data[i] <= 0, all valid[i] <= 0, regardless of CE, FLUSH, handshakes.
REQ-031 After reset: O=0, O_VALID=0, COUNT=0, D_READY=CE & !FLUSH (1 when CE=1).
REQ-032 CLR mid-stream discards all in-flight entries; no output transfer occurs on the reset edge.

Structure
REQ-033 Shared package pipe_pkg holds default constants PIPE_N_DEF=16, PIPE_DEPTH_DEF=4 and the COUNT-width function; no typedefs beyond these.
REQ-034 One sub-module pipe_stage (N-bit data + valid, inputs load/clear/flush), instantiated DEPTH times via generate.
REQ-035 Ready chain and COUNT are combinational in pipe_reg_chain; no latches, no asynchronous paths.

Verification (N=16, DEPTH=4)
REQ-036 CLR=1 one cycle with pipeline full of 0xAAAA -> next cycle O=0x0000, O_VALID=0, COUNT=0, D_READY=1.
REQ-037 Stream D=0x0001..0x0008, D_VALID=1, O_READY=1 -> O_VALID rises 4 cycles after first accept, O=0x0001..0x0008 in consecutive cycles.
REQ-038 O_READY=0, push 0x0011..0x0015 -> first four accepted, COUNT=4, D_READY=0 on fifth; set O_READY=1 -> 0x0011 out, 0x0015 accepted same cycle, COUNT stays 4.
REQ-039 Single entry 0x00F0 pushed then O_READY=0 at tail, push 0x00F1 -> 0x00F1 collapses to stage 2 (COUNT=2), no bubble.
REQ-040 With COUNT=3, FLUSH=1 and D_VALID=1 D=0x1234 -> next cycle COUNT=0, O_VALID=0, 0x1234 never emerges.
REQ-041 CE=0 for 3 cycles mid-stream with D_VALID=1 -> D_READY=0, O_VALID=0, COUNT frozen; after CE=1 sequence resumes intact.
